weight_az_sched: RTL and testbench

Sequencer and memory arbiter for the Weight_Az engine. It runs the four bandwidth-expansion jobs needed per frame: two subframes, each with gamma1 and gamma2. For each job it drives the engine's A, AP and gammaAddr base addresses and start/done handshake. It also grants the engine's scratch memory and math muxes to an external host port, but only between jobs.

---
 rtl/weight_az_pkg.sv | 10 +
 rtl/waz_job_addr.sv | 24 ++
 rtl/weight_az_sched.sv | 112 +++++++++++
 tb/tb_weight_az_sched.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/weight_az_pkg.sv
// weight_az_pkg: shared types and default addresses for the Weight_Az sequencer and its integration.
package weight_az_pkg;
  localparam int ADDR_W = 12;
  localparam logic [ADDR_W-1:0] A_BASE_DEF      = 12'h040;
  localparam logic [ADDR_W-1:0] AP1_BASE_DEF    = 12'h080;
  localparam logic [ADDR_W-1:0] AP2_BASE_DEF    = 12'h0A0;
  localparam logic [ADDR_W-1:0] GAMMA1_ADDR_DEF = 12'h0F0;
  localparam logic [ADDR_W-1:0] GAMMA2_ADDR_DEF = 12'h0F1;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, NEXT, HOLD, FINISH} wazState_t;
endpackage

// File: rtl/waz_job_addr.sv
// waz_job_addr: combinational job index to engine addresses (k -> A, AP, gammaAddr); mod-4096 arithmetic.
//   k in: job index (bit 0 = gamma select, upper bits = subframe); A/AP/gammaAddr out.
module waz_job_addr
  import weight_az_pkg::*;
#(
  parameter int M = 10,
  parameter int KW = 2,
  parameter logic [ADDR_W-1:0] A_BASE = A_BASE_DEF,
  parameter logic [ADDR_W-1:0] AP1_BASE = AP1_BASE_DEF,
  parameter logic [ADDR_W-1:0] AP2_BASE = AP2_BASE_DEF,
  parameter logic [ADDR_W-1:0] GAMMA1_ADDR = GAMMA1_ADDR_DEF,
  parameter logic [ADDR_W-1:0] GAMMA2_ADDR = GAMMA2_ADDR_DEF
) (
  input  logic [KW-1:0]     k,
  output logic [ADDR_W-1:0] A,
  output logic [ADDR_W-1:0] AP,
  output logic [ADDR_W-1:0] gammaAddr
);
  logic [ADDR_W-1:0] off;
  assign off = ADDR_W'(32'(k >> 1) * (M + 1));
  assign A = A_BASE + off;
  assign AP = (k[0] ? AP2_BASE : AP1_BASE) + off;
  assign gammaAddr = k[0] ? GAMMA2_ADDR : GAMMA1_ADDR;
endmodule

// File: rtl/weight_az_sched.sv
// weight_az_sched: runs the 2*NSUB Weight_Az jobs per frame and hands memory to the host between jobs.
//   in : clk, reset (async, active low), start, wazDone, hostReq
//   out: done, busy, wazStart, A, AP, gammaAddr, hostGrant, err (WAZ_SCHED_WDOG_EN only)
//   WAZ_SCHED_WDOG_EN: adds the WAIT watchdog, the WDOG_CYCLES parameter and the err port.
module weight_az_sched
  import weight_az_pkg::*;
#(
  parameter int M = 10,
  parameter int NSUB = 2,
  parameter logic [ADDR_W-1:0] A_BASE = A_BASE_DEF,
  parameter logic [ADDR_W-1:0] AP1_BASE = AP1_BASE_DEF,
  parameter logic [ADDR_W-1:0] AP2_BASE = AP2_BASE_DEF,
  parameter logic [ADDR_W-1:0] GAMMA1_ADDR = GAMMA1_ADDR_DEF,
  parameter logic [ADDR_W-1:0] GAMMA2_ADDR = GAMMA2_ADDR_DEF
`ifdef WAZ_SCHED_WDOG_EN
  , parameter int WDOG_CYCLES = 1023
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic              busy,
  output logic              wazStart,
  input  logic              wazDone,
  output logic [ADDR_W-1:0] A,
  output logic [ADDR_W-1:0] AP,
  output logic [ADDR_W-1:0] gammaAddr,
  input  logic              hostReq,
  output logic              hostGrant
`ifdef WAZ_SCHED_WDOG_EN
  , output logic            err
`endif
);
  localparam int JOBS = 2 * NSUB;
  localparam int KW = JOBS > 2 ? $clog2(JOBS) : 1;
  wazState_t state, nextState;
  logic [KW-1:0] k, kNext;
  logic pending, timeout;
  logic [ADDR_W-1:0] aNext, apNext, gNext;
  waz_job_addr #(
    .M(M), .KW(KW), .A_BASE(A_BASE), .AP1_BASE(AP1_BASE), .AP2_BASE(AP2_BASE),
    .GAMMA1_ADDR(GAMMA1_ADDR), .GAMMA2_ADDR(GAMMA2_ADDR)
  ) u_addr (
    .k(kNext), .A(aNext), .AP(apNext), .gammaAddr(gNext)
  );
  always_comb begin
    nextState = state;
    kNext = k;
    case (state)
      IDLE: if ((start || pending) && !hostGrant) begin
        nextState = LAUNCH;
        kNext = '0;
      end
      LAUNCH: nextState = WAIT;
      WAIT: nextState = wazDone ? NEXT : timeout ? FINISH : WAIT;
      NEXT: if (k == KW'(JOBS - 1)) nextState = FINISH;
      else begin
        kNext = k + 1'b1;
        nextState = hostReq ? HOLD : LAUNCH;
      end
      HOLD: nextState = hostReq ? HOLD : LAUNCH;
      FINISH: begin
        nextState = IDLE;
        kNext = '0;
      end
      default: nextState = IDLE;
    endcase
  end
  // Addresses load only on entry to LAUNCH so they hold still for the whole job
  // and stay at zero after reset until the first job. Grant is only ever set when
  // the next state is IDLE or HOLD, so it can never coincide with wazStart or WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      k <= '0;
      pending <= 1'b0;
      hostGrant <= 1'b0;
      A <= '0;
      AP <= '0;
      gammaAddr <= '0;
    end else begin
      state <= nextState;
      k <= kNext;
      pending <= state == IDLE && nextState == IDLE && (pending || start);
      hostGrant <= nextState == HOLD || (state == IDLE && nextState == IDLE && hostReq);
      if (nextState == LAUNCH) begin
        A <= aNext;
        AP <= apNext;
        gammaAddr <= gNext;
      end
    end
  end
`ifdef WAZ_SCHED_WDOG_EN
  logic [10:0] wdog;
  assign timeout = state == WAIT && !wazDone && wdog == 11'(WDOG_CYCLES - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog <= '0;
      err <= 1'b0;
    end else begin
      wdog <= state == WAIT ? wdog + 1'b1 : '0;
      err <= (state == IDLE && nextState == LAUNCH) ? 1'b0 : timeout ? 1'b1 : err;
    end
  end
`else
  assign timeout = 1'b0;
`endif
  assign wazStart = state == LAUNCH;
  assign done = state == FINISH;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_weight_az_sched.sv
// tb_weight_az_sched: directed scenarios for weight_az_sched with a fixed-latency engine model.
module tb_weight_az_sched;
  logic clk = 0, reset = 0, start = 0, wazDone = 0, hostReq = 0;
  logic done, busy, wazStart, hostGrant;
  logic [11:0] A, AP, gammaAddr;
`ifdef WAZ_SCHED_WDOG_EN
  logic err;
  logic errAtDone = 0;
`endif
  int vec = 0, errs = 0, cyc = 0, d = 5, conflicts = 0;
  bit inJob = 0, engineOn = 1;
  int sQ[$], dQ[$], gQ[$];
  logic [11:0] aQ[$], apQ[$], gaQ[$];
  logic [11:0] expA[4] = '{12'h040, 12'h040, 12'h04B, 12'h04B};
  logic [11:0] expAP[4] = '{12'h080, 12'h0A0, 12'h08B, 12'h0AB};
  logic [11:0] expG[4] = '{12'h0F0, 12'h0F1, 12'h0F0, 12'h0F1};

  weight_az_sched dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
    .wazStart(wazStart), .wazDone(wazDone), .A(A), .AP(AP), .gammaAddr(gammaAddr),
    .hostReq(hostReq), .hostGrant(hostGrant)
`ifdef WAZ_SCHED_WDOG_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(negedge clk);
    #2;
    if (wazStart) begin
      sQ.push_back(cyc); aQ.push_back(A); apQ.push_back(AP); gaQ.push_back(gammaAddr);
    end
    if (done) begin
      dQ.push_back(cyc);
`ifdef WAZ_SCHED_WDOG_EN
      errAtDone = err;
`endif
    end
    if (hostGrant) gQ.push_back(cyc);
    if (hostGrant && (wazStart || inJob)) conflicts++;
    if (!reset) inJob = 0;
    else if (wazStart) inJob = 1;
    else if (wazDone) inJob = 0;
  end

  initial forever begin
    @(negedge clk);
    if (wazStart && reset && engineOn) begin
      repeat (d) @(negedge clk);
      wazDone = 1;
      @(negedge clk);
      wazDone = 0;
    end
  end

  task automatic clearLogs();
    sQ.delete(); dQ.delete(); gQ.delete(); aQ.delete(); apQ.delete(); gaQ.delete();
    conflicts = 0;
  endtask

  task automatic drive(input int n, input int s1, input int s2, input int hLo, input int hHi, output int c0);
    c0 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) c0 = cyc;
      start = (i == s1) || (i == s2);
      hostReq = (i >= hLo) && (i <= hHi);
    end
    @(negedge clk);
    start = 0;
    hostReq = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    vec++; if ({done, busy, wazStart, hostGrant} !== 4'b0) begin errs++; $display("FAIL reset_ctl got %b want 0000", {done, busy, wazStart, hostGrant}); end
    vec++; if (A !== 12'h000) begin errs++; $display("FAIL reset_A got %h want 000", A); end
    vec++; if (AP !== 12'h000) begin errs++; $display("FAIL reset_AP got %h want 000", AP); end
    vec++; if (gammaAddr !== 12'h000) begin errs++; $display("FAIL reset_gamma got %h want 000", gammaAddr); end
    @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_sequence();
    int c0;
    clearLogs();
    drive(40, 0, -1, -1, -2, c0);
    vec++; if (sQ.size() != 4) begin errs++; $display("FAIL seq_starts got %0d want 4", sQ.size()); end
    for (int j = 0; j < 4 && j < sQ.size(); j++) begin
      vec++; if (sQ[j] - c0 != 1 + 7 * j) begin errs++; $display("FAIL seq_start_cyc%0d got %0d want %0d", j, sQ[j] - c0, 1 + 7 * j); end
      vec++; if ({aQ[j], apQ[j], gaQ[j]} !== {expA[j], expAP[j], expG[j]})
        begin errs++; $display("FAIL seq_addr%0d got %h/%h/%h want %h/%h/%h", j, aQ[j], apQ[j], gaQ[j], expA[j], expAP[j], expG[j]); end
    end
    vec++; if (dQ.size() != 1) begin errs++; $display("FAIL seq_dones got %0d want 1", dQ.size()); end
    else begin vec++; if (dQ[0] - c0 != 29) begin errs++; $display("FAIL seq_done_cyc got %0d want 29", dQ[0] - c0); end end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL seq_busy_after got %b want 0", busy); end
  endtask

  task automatic test_host_hold();
    int c0, gFirst, gLast;
    clearLogs();
    drive(50, 0, -1, 5, 11, c0);
    gFirst = gQ.size() > 0 ? gQ[0] - c0 : -1;
    gLast = gQ.size() > 0 ? gQ[gQ.size() - 1] - c0 : -1;
    vec++; if (gQ.size() != 5) begin errs++; $display("FAIL hold_grant_len got %0d want 5", gQ.size()); end
    vec++; if (gFirst != 8) begin errs++; $display("FAIL hold_grant_first got %0d want 8", gFirst); end
    vec++; if (gLast != 12) begin errs++; $display("FAIL hold_grant_last got %0d want 12", gLast); end
    vec++; if (sQ.size() != 4) begin errs++; $display("FAIL hold_starts got %0d want 4", sQ.size()); end
    else begin
      vec++; if (sQ[1] - c0 != 13) begin errs++; $display("FAIL hold_job1_start got %0d want 13", sQ[1] - c0); end
      vec++; if (sQ[3] - c0 != 27) begin errs++; $display("FAIL hold_job3_start got %0d want 27", sQ[3] - c0); end
      vec++; if ({aQ[1], apQ[1], gaQ[1]} !== {12'h040, 12'h0A0, 12'h0F1}) begin errs++; $display("FAIL hold_addr1 got %h/%h/%h want 040/0a0/0f1", aQ[1], apQ[1], gaQ[1]); end
    end
    vec++; if (dQ.size() != 1 || dQ[0] - c0 != 34) begin errs++; $display("FAIL hold_done got n=%0d c=%0d want n=1 c=34", dQ.size(), dQ.size() > 0 ? dQ[0] - c0 : -1); end
    vec++; if (conflicts != 0) begin errs++; $display("FAIL hold_grant_in_job got %0d want 0", conflicts); end
  endtask

  task automatic test_pending_start();
    int c0, gLast;
    clearLogs();
    drive(50, 3, -1, 0, 4, c0);
    gLast = gQ.size() > 0 ? gQ[gQ.size() - 1] - c0 : -1;
    vec++; if (gLast != 5) begin errs++; $display("FAIL pend_grant_last got %0d want 5", gLast); end
    vec++; if (sQ.size() != 4) begin errs++; $display("FAIL pend_starts got %0d want 4", sQ.size()); end
    else begin vec++; if (sQ[0] - c0 != 7) begin errs++; $display("FAIL pend_first_start got %0d want 7", sQ[0] - c0); end end
    vec++; if (dQ.size() != 1 || dQ[0] - c0 != 35) begin errs++; $display("FAIL pend_done got n=%0d c=%0d want n=1 c=35", dQ.size(), dQ.size() > 0 ? dQ[0] - c0 : -1); end
    vec++; if (conflicts != 0) begin errs++; $display("FAIL pend_grant_in_job got %0d want 0", conflicts); end
  endtask

  task automatic test_back_to_back();
    int c0;
    clearLogs();
    drive(45, 0, 12, -1, -2, c0);
    vec++; if (sQ.size() != 4) begin errs++; $display("FAIL b2b_starts got %0d want 4", sQ.size()); end
    vec++; if (dQ.size() != 1) begin errs++; $display("FAIL b2b_dones got %0d want 1", dQ.size()); end
    clearLogs();
    drive(45, 0, 29, -1, -2, c0);
    vec++; if (sQ.size() != 4 || dQ.size() != 1) begin errs++; $display("FAIL b2b_start_at_done got s=%0d d=%0d want s=4 d=1", sQ.size(), dQ.size()); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_busy_after got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int c0 = 0;
    clearLogs();
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (i == 0) c0 = cyc;
      start = (i == 0) || (i == 25);
      reset = !(i >= 17 && i < 22);
      if (i == 17) begin
        #1;
        vec++; if ({done, busy, wazStart, hostGrant} !== 4'b0) begin errs++; $display("FAIL rmid_ctl got %b want 0000", {done, busy, wazStart, hostGrant}); end
        vec++; if ({A, AP, gammaAddr} !== 36'h0) begin errs++; $display("FAIL rmid_addr got %h/%h/%h want 000/000/000", A, AP, gammaAddr); end
      end
    end
    start = 0;
    vec++; if (sQ.size() != 7) begin errs++; $display("FAIL rmid_starts got %0d want 7", sQ.size()); end
    else begin
      vec++; if (sQ[3] - c0 != 26) begin errs++; $display("FAIL rmid_restart_cyc got %0d want 26", sQ[3] - c0); end
      vec++; if ({aQ[3], apQ[3], gaQ[3]} !== {12'h040, 12'h080, 12'h0F0}) begin errs++; $display("FAIL rmid_k0_addr got %h/%h/%h want 040/080/0f0", aQ[3], apQ[3], gaQ[3]); end
      vec++; if ({aQ[6], apQ[6], gaQ[6]} !== {12'h04B, 12'h0AB, 12'h0F1}) begin errs++; $display("FAIL rmid_k3_addr got %h/%h/%h want 04b/0ab/0f1", aQ[6], apQ[6], gaQ[6]); end
    end
    vec++; if (dQ.size() != 1 || dQ[0] - c0 != 54) begin errs++; $display("FAIL rmid_done got n=%0d c=%0d want n=1 c=54", dQ.size(), dQ.size() > 0 ? dQ[0] - c0 : -1); end
  endtask

`ifdef WAZ_SCHED_WDOG_EN
  task automatic test_watchdog();
    int c0;
    clearLogs();
    engineOn = 0;
    drive(1040, 0, -1, -1, -2, c0);
    vec++; if (dQ.size() != 1 || dQ[0] - c0 != 1025) begin errs++; $display("FAIL wdog_done got n=%0d c=%0d want n=1 c=1025", dQ.size(), dQ.size() > 0 ? dQ[0] - c0 : -1); end
    vec++; if (errAtDone !== 1'b1) begin errs++; $display("FAIL wdog_err_at_done got %b want 1", errAtDone); end
    vec++; if (err !== 1'b1) begin errs++; $display("FAIL wdog_err_sticky got %b want 1", err); end
    engineOn = 1;
    drive(5, 0, -1, -1, -2, c0);
    vec++; if (err !== 1'b0) begin errs++; $display("FAIL wdog_err_clear got %b want 0", err); end
    repeat (40) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_host_hold();
    test_pending_start();
    test_back_to_back();
    test_reset_mid();
`ifdef WAZ_SCHED_WDOG_EN
    test_watchdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
